readreg_port_scheduler: RTL and testbench
=========================================

# readreg_port_scheduler

Time-multiplexes a limited number of physical-register-file read ports among the `READREG_WIDTH*2` source-operand reads of one readreg bundle. It sits between the rename→readreg pipeline register and `phyf`. When a bundle needs more reads than there are ports, it spreads the reads over several cycles, buffers the returned data, and stalls the rename side until every operand is collected. Bundles that fit in one cycle pass through with zero added latency.

## Interface
Parameters:
- `REQ_NUM`, default `` `READREG_WIDTH*2 `` (4): operand read requests per bundle; index `2*i+j` is op `i`, source `j`.
- `PORT_NUM`, default 2: `phyf` read ports available; must satisfy 1 ≤ `PORT_NUM` ≤ `REQ_NUM`.
- `ID_WIDTH`, default `` `PHY_REG_ID_WIDTH ``: physical register id width.
- `DATA_WIDTH`, default `` `REG_DATA_WIDTH ``: register data width.

Ports:
- `clk` input 1: clock. One clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: a bundle is present at the readreg input.
- `req_need` input `REQ_NUM`: bit set means that operand needs a `phyf` read (`rsX_need_map && enable && valid`).
- `req_id` input `REQ_NUM`×`ID_WIDTH`: physical register id per operand.
- `phyf_id` output `PORT_NUM`×`ID_WIDTH`: read address per port.
- `phyf_data` input `PORT_NUM`×`DATA_WIDTH`: same-cycle (combinational) read data.
- `phyf_data_valid` input `PORT_NUM`: register-ready bit returned with the data.
- `resp_data` output `REQ_NUM`×`DATA_WIDTH`: collected operand data.
- `resp_data_valid` output `REQ_NUM`: collected ready bit; 0 for operands with `req_need`=0.
- `resp_done` output 1: all needed operands are available this cycle.
- `rename_stall` output 1: hold the rename→readreg register.
- `issue_stall` input 1: downstream stall (`issue_feedback_pack.stall`).
- `flush` input 1: `commit_feedback_pack.enable & flush`.

## Operation
- State is `served[REQ_NUM]`, plus buffers `buf_data` and `buf_valid` per request.
- `pending = req_need & ~served`.
- Grant: each cycle, the `PORT_NUM` lowest-index set bits of `pending` each receive a port, in ascending order; port `p` gets the p-th lowest. Unused ports drive `phyf_id`=0.
- `grant` is the `REQ_NUM` mask of operands granted this cycle.
- `resp_done = req_valid && ((pending & ~grant) == 0)`.
- `rename_stall = req_valid && (!resp_done || issue_stall)`.
- Per operand `r`:
  - if `grant[r]`: `resp_data/valid` bypass from the granted port;
  - else if `served[r]`: from the buffers;
  - else: 0.
- Clock edge, applied in priority order:
  1. `flush`: `served` ← 0.
  2. `req_valid && resp_done && !issue_stall`: `served` ← 0 (the bundle is consumed).
  3. Otherwise, if `req_valid`: `served |= grant`, and buffers capture the granted port data and valid bits.
  4. `!req_valid`: `served` holds.
- `resp_data_valid`=0 is a legal result (operand not yet produced). It is not retried; the downstream feedback-bypass logic handles it.
- A bundle with `req_need`=0 is `resp_done` in the same cycle with no port use.

## Timing
- Reset clears `served`, `buf_data` and `buf_valid`. With `req_valid`=0, all outputs are 0.
- Cycles to `resp_done` = max(1, ceil(popcount(`req_need`)/`PORT_NUM`)). All paths in the completing cycle are combinational.
- `issue_stall` while `resp_done`: the granted data is captured. The next cycle has `pending`=0, `resp_done`=1, and all data comes from the buffers with no re-read.
- `flush` with `issue_stall` in the same cycle: the flush wins and `served` clears.
- `rst` asserted mid-bundle: the state clears immediately. After release, the bundle re-reads from operand 0.
- `req_need` and `req_id` are stable while `rename_stall`=1, because upstream holds them.

## Structure
- `READREG_PORT_NUM` goes in `config.svh`.
- One sub-module, `lowest_n_selector`: an N-hot lowest-bit picker with per-port index outputs, parameterised on `REQ_NUM` and `PORT_NUM`.
- No new package types.

## Test plan
Defaults `REQ_NUM`=4, `PORT_NUM`=2.
- `req_need`=4'b0101, ids {_,9,_,3} → cycle 0: `phyf_id`={3,9}, `resp_done`=1, `rename_stall`=0, `resp_data[0]`/`[2]` = the phyf data.
- `req_need`=4'b1111, ids {1,2,3,4} → cycle 0: ports {1,2}, `rename_stall`=1. Cycle 1: ports {3,4}, `resp_done`=1, all four values correct (2 buffered, 2 bypassed).
- As the previous case with `issue_stall`=1 for cycles 1–2 → cycle 2: `pending`=0, data from buffers, `resp_done`=1, `phyf_id`=0. Cycle 3: stall drops and `served` clears.
- `req_need`=4'b1111, `flush` in cycle 0 → cycle 1 re-grants operands 0,1.
- `rst` pulsed asynchronously mid-bundle → `served`=0 immediately. After release, ports {1,2} again.
- `req_need`=0, `req_valid`=1 → `resp_done`=1, all `resp_data_valid`=0, no port driven.

Source files
------------

// File: rtl/readreg_port_scheduler_pkg.sv
// readreg_port_scheduler_pkg: shared sizing for the readreg read-port scheduler.
package readreg_port_scheduler_pkg;
  localparam int READREG_WIDTH    = 2;
  localparam int READREG_PORT_NUM = 2;
  localparam int PHY_REG_ID_WIDTH = 7;
  localparam int REG_DATA_WIDTH   = 32;
endpackage

// File: rtl/readreg_port_scheduler_lowest_n_selector.sv
// lowest_n_selector: grants up to PORT_NUM lowest set request bits, port p taking the p-th lowest.
module lowest_n_selector #(
  parameter int REQ_NUM  = 4,
  parameter int PORT_NUM = 2,
  parameter int IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic [REQ_NUM-1:0]               i_req,
  output logic [REQ_NUM-1:0]               o_grant,
  output logic [PORT_NUM-1:0][IDX_W-1:0]   o_idx,
  output logic [PORT_NUM-1:0]              o_vld
);
  logic [REQ_NUM-1:0] w_rem;
  logic               w_hit;
  always_comb begin
    w_rem   = i_req;
    w_hit   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    o_vld   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_hit = 1'b0;
      for (int r = 0; r < REQ_NUM; r++) begin
        if (!w_hit && w_rem[r]) begin
          w_hit      = 1'b1;
          w_rem[r]   = 1'b0;
          o_grant[r] = 1'b1;
          o_idx[p]   = IDX_W'(r);
          o_vld[p]   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/readreg_port_scheduler.sv
// readreg_port_scheduler: spreads a bundle's operand reads over the phyf ports across cycles,
// buffering returned data and stalling rename until every needed operand is collected.
module readreg_port_scheduler
  import readreg_port_scheduler_pkg::*;
#(
  parameter int REQ_NUM    = READREG_WIDTH * 2,
  parameter int PORT_NUM   = READREG_PORT_NUM,
  parameter int ID_WIDTH   = PHY_REG_ID_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_req_valid,
  input  logic [REQ_NUM-1:0]                  i_req_need,
  input  logic [REQ_NUM-1:0][ID_WIDTH-1:0]    i_req_id,
  output logic [PORT_NUM-1:0][ID_WIDTH-1:0]   o_phyf_id,
  input  logic [PORT_NUM-1:0][DATA_WIDTH-1:0] i_phyf_data,
  input  logic [PORT_NUM-1:0]                 i_phyf_data_valid,
  output logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  o_resp_data,
  output logic [REQ_NUM-1:0]                  o_resp_data_valid,
  output logic                                o_resp_done,
  output logic                                o_rename_stall,
  input  logic                                i_issue_stall,
  input  logic                                i_flush
);
  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [REQ_NUM-1:0]                  r_served;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  r_buf_data;
  logic [REQ_NUM-1:0]                  r_buf_valid;
  logic [REQ_NUM-1:0]                  w_pending;
  logic [REQ_NUM-1:0]                  w_grant;
  logic [PORT_NUM-1:0][IDX_W-1:0]      w_idx;
  logic [PORT_NUM-1:0]                 w_pvld;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  w_gdata;
  logic [REQ_NUM-1:0]                  w_gvld;

  assign w_pending      = i_req_valid ? (i_req_need & ~r_served) : '0;
  assign o_resp_done    = i_req_valid && ((w_pending & ~w_grant) == '0);
  assign o_rename_stall = i_req_valid && (!o_resp_done || i_issue_stall);

  lowest_n_selector #(
    .REQ_NUM (REQ_NUM),
    .PORT_NUM(PORT_NUM),
    .IDX_W   (IDX_W)
  ) u_sel (
    .i_req  (w_pending),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_vld  (w_pvld)
  );

  // Route each port's read back to the operand it was granted to.
  always_comb begin
    o_phyf_id = '0;
    w_gdata   = '0;
    w_gvld    = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (w_pvld[p]) begin
        o_phyf_id[p]      = i_req_id[w_idx[p]];
        w_gdata[w_idx[p]] = i_phyf_data[p];
        w_gvld[w_idx[p]]  = i_phyf_data_valid[p];
      end
    end
  end

  always_comb begin
    o_resp_data       = '0;
    o_resp_data_valid = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      o_resp_data[r]       = w_grant[r] ? w_gdata[r] : (i_req_valid && r_served[r]) ? r_buf_data[r] : '0;
      o_resp_data_valid[r] = w_grant[r] ? w_gvld[r] : (i_req_valid && r_served[r] && r_buf_valid[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_served    <= '0;
      r_buf_data  <= '0;
      r_buf_valid <= '0;
    end else if (i_flush || (o_resp_done && !i_issue_stall)) begin
      r_served <= '0;
    end else if (i_req_valid) begin
      r_served <= r_served | w_grant;
      for (int r = 0; r < REQ_NUM; r++) begin
        if (w_grant[r]) begin
          r_buf_data[r]  <= w_gdata[r];
          r_buf_valid[r] <= w_gvld[r];
        end
      end
    end
  end
endmodule

// File: tb/tb_readreg_port_scheduler.sv
// tb_readreg_port_scheduler: directed plus random stimulus against a sorted-operand-list reference model.
module tb_readreg_port_scheduler;
  import readreg_port_scheduler_pkg::*;
  localparam int R  = READREG_WIDTH * 2;
  localparam int P  = READREG_PORT_NUM;
  localparam int IW = PHY_REG_ID_WIDTH;
  localparam int DW = REG_DATA_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid;
  logic [R-1:0]           req_need;
  logic [R-1:0][IW-1:0]   req_id;
  logic [P-1:0][IW-1:0]   phyf_id;
  logic [P-1:0][DW-1:0]   phyf_data;
  logic [P-1:0]           phyf_data_valid;
  logic [R-1:0][DW-1:0]   resp_data;
  logic [R-1:0]           resp_data_valid;
  logic                   resp_done;
  logic                   rename_stall;
  logic                   issue_stall;
  logic                   flush;

  int errors = 0;
  int checks = 0;
  int epoch  = 1;
  int m_cnt  = 0;
  logic [DW-1:0] m_d [R];
  logic          m_v [R];

  readreg_port_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (req_valid),
    .i_req_need       (req_need),
    .i_req_id         (req_id),
    .o_phyf_id        (phyf_id),
    .i_phyf_data      (phyf_data),
    .i_phyf_data_valid(phyf_data_valid),
    .o_resp_data      (resp_data),
    .o_resp_data_valid(resp_data_valid),
    .o_resp_done      (resp_done),
    .o_rename_stall   (rename_stall),
    .i_issue_stall    (issue_stall),
    .i_flush          (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] phy_d(input logic [IW-1:0] id, input int ep);
    return DW'({ep[23:0], 1'b0, id});
  endfunction

  function automatic logic phy_v(input logic [IW-1:0] id, input int ep);
    return id[0] ^ ep[0];
  endfunction

  always_comb begin
    for (int p = 0; p < P; p++) begin
      phyf_data[p]       = phy_d(phyf_id[p], epoch);
      phyf_data_valid[p] = phy_v(phyf_id[p], epoch);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Needed operands form an ascending list; each cycle serves the next P entries of it.
  task automatic cycle(input string tag);
    int lst[$];
    int n, hi, nxt;
    logic [P-1:0][IW-1:0] e_id;
    logic [R-1:0][DW-1:0] e_d;
    logic [R-1:0]         e_v;
    logic                 e_done, e_stall;
    #4;
    e_id = '0;
    e_d  = '0;
    e_v  = '0;
    for (int r = 0; r < R; r++) if (req_need[r]) lst.push_back(r);
    n  = lst.size();
    hi = (m_cnt + P < n) ? m_cnt + P : n;
    e_done  = req_valid && (hi >= n);
    e_stall = req_valid && (!e_done || issue_stall);
    if (req_valid) begin
      for (int k = 0; k < hi; k++) begin
        if (k >= m_cnt) begin
          e_id[k - m_cnt] = req_id[lst[k]];
          e_d[lst[k]]     = phy_d(req_id[lst[k]], epoch);
          e_v[lst[k]]     = phy_v(req_id[lst[k]], epoch);
        end else begin
          e_d[lst[k]] = m_d[lst[k]];
          e_v[lst[k]] = m_v[lst[k]];
        end
      end
    end
    chk({tag, ".phyf_id"}, 256'(phyf_id), 256'(e_id));
    chk({tag, ".resp_data"}, 256'(resp_data), 256'(e_d));
    chk({tag, ".resp_valid"}, 256'(resp_data_valid), 256'(e_v));
    chk({tag, ".done"}, 256'(resp_done), 256'(e_done));
    chk({tag, ".rename_stall"}, 256'(rename_stall), 256'(e_stall));
    nxt = m_cnt;
    if (flush || (e_done && !issue_stall)) nxt = 0;
    else if (req_valid) begin
      for (int k = m_cnt; k < hi; k++) begin
        m_d[lst[k]] = e_d[lst[k]];
        m_v[lst[k]] = e_v[lst[k]];
      end
      nxt = hi;
    end
    @(posedge clk);
    #1;
    m_cnt = nxt;
    epoch++;
  endtask

  task automatic drive(input logic v, input logic [R-1:0] nd, input logic st, input logic fl);
    req_valid   = v;
    req_need    = nd;
    issue_stall = st;
    flush       = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    req_id = '0;
    for (int r = 0; r < R; r++) begin
      m_d[r] = '0;
      m_v[r] = 1'b0;
    end
    @(posedge clk);
    #1;
    cycle("reset_idle");
    rst = 1'b0;
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    cycle("idle_outputs_zero");

    req_id = {7'd0, 7'd9, 7'd0, 7'd3};
    drive(1'b1, 4'b0101, 1'b0, 1'b0);
    cycle("sparse_c0");
    chk("sparse_served_cleared", 256'(m_cnt), 256'(0));

    req_id = {7'd4, 7'd3, 7'd2, 7'd1};
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    cycle("full_c0");
    cycle("full_c1");

    cycle("stall_c0");
    issue_stall = 1'b1;
    cycle("stall_c1");
    cycle("stall_c2_buffered");
    issue_stall = 1'b0;
    cycle("stall_c3_consume");
    cycle("stall_c4_regrant");

    flush = 1'b1;
    cycle("flush_c0");
    flush = 1'b0;
    cycle("flush_c1_regrant");
    cycle("flush_c2");

    cycle("rst_c0");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ports", 256'(phyf_id), 256'({7'd2, 7'd1}));
    chk("async_rst_done", 256'(resp_done), 256'(0));
    m_cnt = 0;
    #1 rst = 1'b0;
    cycle("rst_after_c0");
    cycle("rst_after_c1");

    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    cycle("no_need");
    drive(1'b1, 4'b1000, 1'b1, 1'b0);
    req_id = {7'd127, 7'd5, 7'd6, 7'd7};
    cycle("single_high_stall");
    issue_stall = 1'b0;
    cycle("single_high_release");

    for (int i = 0; i < 400; i++) begin
      if (m_cnt == 0 && $urandom_range(0, 2) == 0) begin
        req_need = R'($urandom);
        for (int r = 0; r < R; r++) req_id[r] = IW'($urandom);
      end
      req_valid   = ($urandom_range(0, 7) != 0);
      issue_stall = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
